riscv_issue_stage: RTL and testbench
====================================

Name: riscv_issue_stage

Overview:
- Dual-issue in-order issue stage, directly downstream of the fetch instruction queue.
- Each cycle, inspects the queue head pair (slot0/slot1) and decides pop0/pop1 from register-hazard and functional-unit checks.
- Issued instructions are registered into a two-slot issue register toward execute.
- Keeps a 32-entry register scoreboard that is cleared by writeback.

Parameters:
- RD_MASK_X0, 1, when 1, x0 is never marked busy and never causes a hazard (must stay 1 for RV32I).

Ports:
- clk  in  1  clock
- srst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush (branch mispredict/trap)
- valid0  in  1  queue head slot0 valid
- pc0  in  32  slot0 PC
- inst0  in  32  slot0 instruction
- unit_usage0  in  `UNIT_NUM  slot0 functional-unit one-hot
- valid1  in  1  queue head slot1 valid
- pc1  in  32  slot1 PC
- inst1  in  32  slot1 instruction
- unit_usage1  in  `UNIT_NUM  slot1 functional-unit one-hot
- pop0  out  1  slot0 issued this cycle (combinational)
- pop1  out  1  slot1 issued this cycle (combinational)
- ex_ready  in  1  execute accepts the issue register this cycle
- iss0_valid / iss1_valid  out  1  issue register slot valid
- iss0_pc / iss1_pc  out  32  issued PC
- iss0_inst / iss1_inst  out  32  issued instruction
- iss0_unit / iss1_unit  out  `UNIT_NUM  issued unit usage
- wb0_valid, wb1_valid  in  1  writeback strobes
- wb0_rd, wb1_rd  in  5  writeback destination registers

Behaviour:
- Decode, per slot, from opcode inst[6:0]:
  - rd_used unless STORE (0100011) or BRANCH (1100011).
  - rs1_used unless LUI, AUIPC or JAL.
  - rs2_used for OP (0110011), STORE and BRANCH.
  - Fields: rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20]. Register 0 is never a hazard.
- busy[31:0]:
  - busy = sb | rd-bits of valid iss slots with rd_used.
  - sb is a register, set when an iss slot is consumed (iss_valid && ex_ready), cleared by wbN_valid on wbN_rd.
  - Set and clear of the same register in the same cycle: set wins.
- issue0 = valid0 && ex_ready && !flush && no RAW (used rs busy) && no WAW (rd busy).
- issue1 = valid1 && ex_ready && !flush && own RAW/WAW clear && (!valid0 || (issue0 && pair_ok)).
  - pair_ok: (unit_usage0 & unit_usage1) == 0.
  - pair_ok: slot1 used rs1/rs2 != slot0 rd (when slot0 rd_used, rd != 0).
  - pair_ok: slot1 rd != slot0 rd when both are used.
- In-order rule: valid0 && !issue0 forces issue1 = 0. A slot0 already popped (valid0 = 0) lets slot1 issue alone.
- pop0 = issue0, pop1 = issue1, same cycle.
- Issue register:
  - On ex_ready, all iss fields load from the slots.
  - issN_valid <= issueN, so a non-issued slot loads valid = 0.
  - When ex_ready = 0, the register holds and pops are 0.
- Latency: queue head to iss outputs is 1 cycle.
- Flush: iss0_valid and iss1_valid <= 0. No pops in the flush cycle. sb is untouched, because older consumed instructions still write back.
- Reset: all iss outputs 0 (valid, pc, inst, unit), sb = 0, pop0 = pop1 = 0. Reset overrides flush and writeback. Reset mid-stall discards the held pair.

Optional Feature:
- WB_BYPASS_EN defined: hazard checks use busy & ~(registers written back this cycle), so a consumer issues in the same cycle as its producer's writeback.
- Undefined: a consumer issues no earlier than 1 cycle after writeback.

Test Plan:
- Independent pair (add x1,x2,x3 / sub x4,x5,x6; ALU vs MUL unit), ex_ready = 1 -> pop0 = pop1 = 1 same cycle; next cycle iss0/iss1 valid with pcs 0x100/0x104.
- Intra-pair RAW (addi x5,x0,1 / add x6,x5,x5) -> pop0 = 1, pop1 = 0. Next cycle valid0 = 0, valid1 = 1 -> pop1 = 0 while x5 busy. After wb0_valid with wb0_rd = 5 -> pop1 = 1 the following cycle (same cycle with WB_BYPASS_EN).
- Structural: both slots have unit_usage = ALU bit -> pop0 = 1, pop1 = 0; slot1 issues alone next cycle.
- ex_ready = 0 for 3 cycles with a valid pair -> pops 0; iss registers and outputs are stable across the stall.
- flush while iss0_valid = 1 with rd = x7 -> next cycle iss valids 0, x7 not busy, and a lw x8,0(x7) issues immediately.
- wb and consume of x9 in the same cycle (new writer of x9 leaves iss) -> x9 remains busy.

Source files
------------

// File: rtl/riscv_issue_stage.sv
// Dual-issue in-order issue stage with a 32-entry register scoreboard.
// Optional feature: define WB_BYPASS_EN to let a consumer issue in its producer's writeback cycle.
`ifndef UNIT_NUM
`define UNIT_NUM 4
`endif

module riscv_issue_stage #(
  parameter bit RD_MASK_X0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 flush,
  input  logic                 valid0,
  input  logic [31:0]          pc0,
  input  logic [31:0]          inst0,
  input  logic [`UNIT_NUM-1:0] unit_usage0,
  input  logic                 valid1,
  input  logic [31:0]          pc1,
  input  logic [31:0]          inst1,
  input  logic [`UNIT_NUM-1:0] unit_usage1,
  output logic                 pop0,
  output logic                 pop1,
  input  logic                 ex_ready,
  output logic                 iss0_valid,
  output logic                 iss1_valid,
  output logic [31:0]          iss0_pc,
  output logic [31:0]          iss1_pc,
  output logic [31:0]          iss0_inst,
  output logic [31:0]          iss1_inst,
  output logic [`UNIT_NUM-1:0] iss0_unit,
  output logic [`UNIT_NUM-1:0] iss1_unit,
  input  logic                 wb0_valid,
  input  logic [4:0]           wb0_rd,
  input  logic                 wb1_valid,
  input  logic [4:0]           wb1_rd
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic       rd_used;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  // Use flags already exclude x0 so every later comparison can ignore it.
  function automatic logic live(input logic used, input logic [4:0] r);
    return used && (!RD_MASK_X0 || (r != 5'd0));
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [6:0] op;
    op         = inst[6:0];
    d.rd       = inst[11:7];
    d.rs1      = inst[19:15];
    d.rs2      = inst[24:20];
    d.rd_used  = live(!(op == OP_STORE || op == OP_BRANCH), d.rd);
    d.rs1_used = live(!(op == OP_LUI || op == OP_AUIPC || op == OP_JAL), d.rs1);
    d.rs2_used = live(op == OP_OP || op == OP_STORE || op == OP_BRANCH, d.rs2);
    return d;
  endfunction

  function automatic logic [31:0] reg_bit(input logic [4:0] r, input logic en);
    return en ? (32'd1 << r) : 32'd0;
  endfunction

  function automatic logic [31:0] iss_rd_bit(input logic [31:0] inst, input logic v);
    dec_t d;
    d = decode(inst);
    return reg_bit(d.rd, v && d.rd_used);
  endfunction

  function automatic logic hazard(input dec_t d, input logic [31:0] b);
    return (d.rs1_used && b[d.rs1]) || (d.rs2_used && b[d.rs2]) || (d.rd_used && b[d.rd]);
  endfunction

  dec_t        d0, d1;
  logic [31:0] sb, pend, wb_clr, hz_busy;
  logic        pair_ok, issue0, issue1;

  assign d0 = decode(inst0);
  assign d1 = decode(inst1);

  // Destinations still sitting in the issue register count as busy alongside the scoreboard.
  always_comb begin
    pend   = iss_rd_bit(iss0_inst, iss0_valid) | iss_rd_bit(iss1_inst, iss1_valid);
    wb_clr = reg_bit(wb0_rd, wb0_valid) | reg_bit(wb1_rd, wb1_valid);
`ifdef WB_BYPASS_EN
    // Only the scoreboard part is bypassed; a writer still in the issue register stays busy.
    hz_busy = (sb & ~wb_clr) | pend;
`else
    hz_busy = sb | pend;
`endif
  end

  always_comb begin
    pair_ok = ((unit_usage0 & unit_usage1) == '0) &&
              !(d0.rd_used && ((d1.rs1_used && (d1.rs1 == d0.rd)) ||
                               (d1.rs2_used && (d1.rs2 == d0.rd)) ||
                               (d1.rd_used  && (d1.rd  == d0.rd))));
    issue0  = srst_n && valid0 && ex_ready && !flush && !hazard(d0, hz_busy);
    issue1  = srst_n && valid1 && ex_ready && !flush && !hazard(d1, hz_busy) &&
              (!valid0 || (issue0 && pair_ok));
  end

  assign pop0 = issue0;
  assign pop1 = issue1;

  // A flushed issue register is discarded, so its destinations never enter the scoreboard.
  always_ff @(posedge clk) begin
    if (!srst_n)
      sb <= '0;
    else
      sb <= (sb & ~wb_clr) | ((ex_ready && !flush) ? pend : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
      iss0_pc    <= '0;
      iss1_pc    <= '0;
      iss0_inst  <= '0;
      iss1_inst  <= '0;
      iss0_unit  <= '0;
      iss1_unit  <= '0;
    end else if (flush) begin
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
    end else if (ex_ready) begin
      iss0_valid <= issue0;
      iss1_valid <= issue1;
      iss0_pc    <= pc0;
      iss1_pc    <= pc1;
      iss0_inst  <= inst0;
      iss1_inst  <= inst1;
      iss0_unit  <= unit_usage0;
      iss1_unit  <= unit_usage1;
    end
  end

endmodule

// File: tb/tb_riscv_issue_stage.sv
// Directed self-checking bench for riscv_issue_stage: pairing, hazards, stall, flush, scoreboard.
`ifndef UNIT_NUM
`define UNIT_NUM 4
`endif

module tb_riscv_issue_stage;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  localparam logic [`UNIT_NUM-1:0] ALU = 4'b0001;
  localparam logic [`UNIT_NUM-1:0] MUL = 4'b0010;
  localparam logic [`UNIT_NUM-1:0] LSU = 4'b0100;

  logic clk, srst_n, flush, ex_ready;
  logic valid0, valid1, pop0, pop1;
  logic [31:0] pc0, pc1, inst0, inst1;
  logic [`UNIT_NUM-1:0] unit_usage0, unit_usage1;
  logic iss0_valid, iss1_valid;
  logic [31:0] iss0_pc, iss1_pc, iss0_inst, iss1_inst;
  logic [`UNIT_NUM-1:0] iss0_unit, iss1_unit;
  logic wb0_valid, wb1_valid;
  logic [4:0] wb0_rd, wb1_rd;

  int checks = 0;
  int passed = 0;

  riscv_issue_stage dut (
    .clk(clk), .srst_n(srst_n), .flush(flush),
    .valid0(valid0), .pc0(pc0), .inst0(inst0), .unit_usage0(unit_usage0),
    .valid1(valid1), .pc1(pc1), .inst1(inst1), .unit_usage1(unit_usage1),
    .pop0(pop0), .pop1(pop1), .ex_ready(ex_ready),
    .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
    .iss0_pc(iss0_pc), .iss1_pc(iss1_pc),
    .iss0_inst(iss0_inst), .iss1_inst(iss1_inst),
    .iss0_unit(iss0_unit), .iss1_unit(iss1_unit),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic applyStimulus(
    input logic v0, input logic [31:0] p0, input logic [31:0] i0, input logic [`UNIT_NUM-1:0] u0,
    input logic v1, input logic [31:0] p1, input logic [31:0] i1, input logic [`UNIT_NUM-1:0] u1);
    valid0 = v0; pc0 = p0; inst0 = i0; unit_usage0 = u0;
    valid1 = v1; pc1 = p1; inst1 = i1; unit_usage1 = u1;
  endtask

  task automatic setWb(input logic v0, input logic [4:0] r0, input logic v1, input logic [4:0] r1);
    wb0_valid = v0; wb0_rd = r0; wb1_valid = v1; wb1_rd = r1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive at the falling edge, check combinational pops 1ns later.
  task automatic atNeg();
    @(negedge clk);
  endtask

  task automatic afterPos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    setWb(1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b1, 32'h100, enc_add(5'd1, 5'd2, 5'd3), ALU,
                  1'b1, 32'h104, enc_sub(5'd4, 5'd5, 5'd6), MUL);
    afterPos();
    afterPos();
    atNeg(); #1;
    checkOutput("rst_pop0", pop0, 0);
    checkOutput("rst_pop1", pop1, 0);
    checkOutput("rst_iss0_valid", iss0_valid, 0);
    checkOutput("rst_iss1_valid", iss1_valid, 0);
    checkOutput("rst_iss0_pc", iss0_pc, 0);
    checkOutput("rst_iss1_inst", iss1_inst, 0);
    checkOutput("rst_iss0_unit", iss0_unit, 0);

    // Independent pair
    atNeg(); srst_n = 1'b1; #1;
    checkOutput("pair_pop0", pop0, 1);
    checkOutput("pair_pop1", pop1, 1);
    afterPos();
    checkOutput("pair_iss0_valid", iss0_valid, 1);
    checkOutput("pair_iss1_valid", iss1_valid, 1);
    checkOutput("pair_iss0_pc", iss0_pc, 32'h100);
    checkOutput("pair_iss1_pc", iss1_pc, 32'h104);
    checkOutput("pair_iss0_inst", iss0_inst, 32'h003100B3);
    checkOutput("pair_iss1_inst", iss1_inst, 32'h40628233);
    checkOutput("pair_iss1_unit", iss1_unit, MUL);

    // Intra-pair RAW on x5
    atNeg();
    applyStimulus(1'b1, 32'h108, enc_addi(5'd5, 5'd0, 12'd1), ALU,
                  1'b1, 32'h10C, enc_add(5'd6, 5'd5, 5'd5), MUL);
    #1;
    checkOutput("raw_pop0", pop0, 1);
    checkOutput("raw_pop1", pop1, 0);
    afterPos();
    checkOutput("raw_iss0_pc", iss0_pc, 32'h108);
    checkOutput("raw_iss1_valid", iss1_valid, 0);

    atNeg();
    applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b1, 32'h10C, enc_add(5'd6, 5'd5, 5'd5), MUL);
    #1;
    checkOutput("raw_wait_pop1", pop1, 0);
    afterPos();
    checkOutput("raw_wait_iss1_valid", iss1_valid, 0);

    atNeg(); setWb(1'b1, 5'd5, 1'b0, 5'd0); #1;
    checkOutput("raw_wb_pop1", pop1, BYP);
    afterPos();
    checkOutput("raw_wb_iss1_valid", iss1_valid, BYP);

    atNeg(); setWb(1'b0, 5'd0, 1'b0, 5'd0); valid1 = !BYP; #1;
    checkOutput("raw_after_wb_pop1", pop1, !BYP);
    afterPos();
    checkOutput("raw_after_wb_iss1_valid", iss1_valid, !BYP);
    checkOutput("raw_after_wb_iss1_pc", iss1_pc, 32'h10C);

    // Retire x1/x4 then x6
    atNeg();
    applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b0, 32'h0, 32'h0, '0);
    setWb(1'b1, 5'd1, 1'b1, 5'd4);
    afterPos();

    // Structural conflict: both ALU
    atNeg();
    setWb(1'b1, 5'd6, 1'b0, 5'd0);
    applyStimulus(1'b1, 32'h200, enc_add(5'd10, 5'd11, 5'd12), ALU,
                  1'b1, 32'h204, enc_add(5'd13, 5'd14, 5'd15), ALU);
    #1;
    checkOutput("struct_pop0", pop0, 1);
    checkOutput("struct_pop1", pop1, 0);
    afterPos();
    checkOutput("struct_iss1_valid", iss1_valid, 0);

    atNeg();
    setWb(1'b0, 5'd0, 1'b0, 5'd0);
    valid0 = 1'b0;
    #1;
    checkOutput("struct_alone_pop1", pop1, 1);
    afterPos();
    checkOutput("struct_alone_iss0_valid", iss0_valid, 0);
    checkOutput("struct_alone_iss1_valid", iss1_valid, 1);
    checkOutput("struct_alone_iss1_pc", iss1_pc, 32'h204);

    // Three-cycle stall; x10 retires during the first stall cycle
    atNeg();
    ex_ready = 1'b0;
    setWb(1'b1, 5'd10, 1'b0, 5'd0);
    applyStimulus(1'b1, 32'h300, enc_add(5'd16, 5'd17, 5'd18), ALU,
                  1'b1, 32'h304, enc_sub(5'd19, 5'd20, 5'd21), MUL);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_pop0", pop0, 0);
      checkOutput("stall_pop1", pop1, 0);
      afterPos();
      checkOutput("stall_iss1_valid", iss1_valid, 1);
      checkOutput("stall_iss1_pc", iss1_pc, 32'h204);
      checkOutput("stall_iss0_valid", iss0_valid, 0);
      atNeg();
      setWb(1'b0, 5'd0, 1'b0, 5'd0);
    end
    ex_ready = 1'b1;
    #1;
    checkOutput("unstall_pop0", pop0, 1);
    checkOutput("unstall_pop1", pop1, 1);
    afterPos();
    checkOutput("unstall_iss0_pc", iss0_pc, 32'h300);
    checkOutput("unstall_iss1_pc", iss1_pc, 32'h304);

    // Flush with x7 writer in the issue register
    atNeg();
    setWb(1'b1, 5'd13, 1'b0, 5'd0);
    applyStimulus(1'b1, 32'h400, enc_addi(5'd7, 5'd0, 12'd5), ALU,
                  1'b0, 32'h0, 32'h0, '0);
    #1;
    checkOutput("x7_pop0", pop0, 1);
    afterPos();
    checkOutput("x7_iss0_valid", iss0_valid, 1);

    atNeg();
    setWb(1'b0, 5'd0, 1'b0, 5'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 32'h404, enc_lw(5'd8, 5'd7, 12'd0), LSU,
                  1'b0, 32'h0, 32'h0, '0);
    #1;
    checkOutput("flush_pop0", pop0, 0);
    afterPos();
    checkOutput("flush_iss0_valid", iss0_valid, 0);

    atNeg(); flush = 1'b0; #1;
    checkOutput("post_flush_lw_pop0", pop0, 1);
    afterPos();
    checkOutput("post_flush_iss0_pc", iss0_pc, 32'h404);
    checkOutput("post_flush_iss0_unit", iss0_unit, LSU);

    // Writeback and consume of x9 in the same cycle: set wins
    atNeg();
    applyStimulus(1'b1, 32'h500, enc_addi(5'd9, 5'd0, 12'd1), ALU,
                  1'b0, 32'h0, 32'h0, '0);
    #1;
    checkOutput("x9_pop0", pop0, 1);
    afterPos();
    atNeg();
    valid0 = 1'b0;
    setWb(1'b1, 5'd9, 1'b0, 5'd0);
    afterPos();
    atNeg();
    setWb(1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b1, 32'h504, enc_addi(5'd20, 5'd9, 12'd1), ALU,
                  1'b0, 32'h0, 32'h0, '0);
    #1;
    checkOutput("x9_still_busy_pop0", pop0, 0);
    afterPos();

    // Reset during a stall discards the held instruction and clears the scoreboard
    atNeg();
    applyStimulus(1'b1, 32'h600, enc_add(5'd21, 5'd22, 5'd23), ALU,
                  1'b0, 32'h0, 32'h0, '0);
    #1;
    checkOutput("pre_rst_pop0", pop0, 1);
    afterPos();
    atNeg(); ex_ready = 1'b0; srst_n = 1'b0; #1;
    checkOutput("mid_rst_pop0", pop0, 0);
    afterPos();
    checkOutput("mid_rst_iss0_valid", iss0_valid, 0);
    checkOutput("mid_rst_iss0_pc", iss0_pc, 0);
    atNeg();
    srst_n = 1'b1; ex_ready = 1'b1;
    applyStimulus(1'b1, 32'h700, enc_add(5'd1, 5'd9, 5'd16), ALU,
                  1'b0, 32'h0, 32'h0, '0);
    #1;
    checkOutput("post_rst_sb_clear_pop0", pop0, 1);
    afterPos();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
